// File: rtl/blend_factor_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | blend_factor_stage_if : fragment, config and mixer-side bundle             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface blend_factor_stage_if #(
   parameter int SUB_PIXEL_WIDTH = 8,
   parameter int SIDEBAND_WIDTH  = 32
);
   localparam int PIXEL_WIDTH = 4 * SUB_PIXEL_WIDTH;

   logic                      s_valid;
   logic                      s_ready;
   logic [PIXEL_WIDTH-1:0]    s_src_color;
   logic [PIXEL_WIDTH-1:0]    s_dst_color;
   logic [SIDEBAND_WIDTH-1:0] s_sideband;

   logic                      conf_valid;
   logic                      conf_ready;
   logic [3:0]                conf_sfactor;
   logic [3:0]                conf_dfactor;

   logic                      m_valid;
   logic                      m_ready;
   logic [PIXEL_WIDTH-1:0]    m_colorA;
   logic [PIXEL_WIDTH-1:0]    m_colorB;
   logic [PIXEL_WIDTH-1:0]    m_colorC;
   logic [PIXEL_WIDTH-1:0]    m_colorD;
   logic [SIDEBAND_WIDTH-1:0] m_sideband;

   modport slave (
      input  s_valid, s_src_color, s_dst_color, s_sideband,
      output s_ready,
      input  conf_valid, conf_sfactor, conf_dfactor,
      output conf_ready,
      output m_valid, m_colorA, m_colorB, m_colorC, m_colorD, m_sideband,
      input  m_ready
   );

   modport master (
      output s_valid, s_src_color, s_dst_color, s_sideband,
      input  s_ready,
      output conf_valid, conf_sfactor, conf_dfactor,
      input  conf_ready,
      input  m_valid, m_colorA, m_colorB, m_colorC, m_colorD, m_sideband,
      output m_ready
   );
endinterface
`default_nettype wire

// File: rtl/blend_factor_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | blend_factor_stage : computes src/dst blend factors, 1-cycle + skid stage  |
// | Option: BLEND_SRC_ALPHA_SATURATE_EN enables factor code 10.  Rev 1.0       |
// +----------------------------------------------------------------------------+
module blend_factor_stage #(
   parameter int SUB_PIXEL_WIDTH = 8,
   parameter int SIDEBAND_WIDTH  = 32
) (
   input  logic                 aclk,
   input  logic                 reset,
   blend_factor_stage_if.slave  bus
);
   localparam int PIXEL_WIDTH = 4 * SUB_PIXEL_WIDTH;

   localparam logic [3:0] F_ZERO          = 4'd0;
   localparam logic [3:0] F_ONE           = 4'd1;
   localparam logic [3:0] F_SRC_COLOR     = 4'd2;
   localparam logic [3:0] F_INV_SRC_COLOR = 4'd3;
   localparam logic [3:0] F_DST_COLOR     = 4'd4;
   localparam logic [3:0] F_INV_DST_COLOR = 4'd5;
   localparam logic [3:0] F_SRC_ALPHA     = 4'd6;
   localparam logic [3:0] F_INV_SRC_ALPHA = 4'd7;
   localparam logic [3:0] F_DST_ALPHA     = 4'd8;
   localparam logic [3:0] F_INV_DST_ALPHA = 4'd9;
`ifdef BLEND_SRC_ALPHA_SATURATE_EN
   localparam logic [3:0] F_SRC_ALPHA_SAT = 4'd10;
`endif

   typedef enum logic [0:0] {
      CFG_RUN    = 1'b0,
      CFG_UPDATE = 1'b1
   } cfg_state_e;

   function automatic logic [PIXEL_WIDTH-1:0] factor_f(
      input logic [3:0]             code,
      input logic [PIXEL_WIDTH-1:0] src,
      input logic [PIXEL_WIDTH-1:0] dst
   );
      logic [SUB_PIXEL_WIDTH-1:0] alpha_s;
      logic [SUB_PIXEL_WIDTH-1:0] alpha_d;
`ifdef BLEND_SRC_ALPHA_SATURATE_EN
      logic [SUB_PIXEL_WIDTH-1:0] sat;
`endif
      alpha_s = src[SUB_PIXEL_WIDTH-1:0];
      alpha_d = dst[SUB_PIXEL_WIDTH-1:0];
`ifdef BLEND_SRC_ALPHA_SATURATE_EN
      sat = (alpha_s < ~alpha_d) ? alpha_s : ~alpha_d;
`endif
      case (code)
         F_ZERO:          factor_f = '0;
         F_ONE:           factor_f = '1;
         F_SRC_COLOR:     factor_f = src;
         F_INV_SRC_COLOR: factor_f = ~src;
         F_DST_COLOR:     factor_f = dst;
         F_INV_DST_COLOR: factor_f = ~dst;
         F_SRC_ALPHA:     factor_f = {4{alpha_s}};
         F_INV_SRC_ALPHA: factor_f = ~{4{alpha_s}};
         F_DST_ALPHA:     factor_f = {4{alpha_d}};
         F_INV_DST_ALPHA: factor_f = ~{4{alpha_d}};
`ifdef BLEND_SRC_ALPHA_SATURATE_EN
         F_SRC_ALPHA_SAT: factor_f = {{3{sat}}, {SUB_PIXEL_WIDTH{1'b1}}};
`endif
         default:         factor_f = '0;
      endcase
   endfunction

   cfg_state_e                cfg_state_q;
   logic                      conf_ready_q;
   logic [3:0]                sfactor_q;
   logic [3:0]                dfactor_q;

   logic                      s_ready_q,   s_ready_d;
   logic                      out_valid_q, out_valid_d;
   logic                      skid_full_q, skid_full_d;
   logic [PIXEL_WIDTH-1:0]    skid_src_q,  skid_dst_q;
   logic [SIDEBAND_WIDTH-1:0] skid_sb_q;
   logic [PIXEL_WIDTH-1:0]    out_a_q, out_b_q, out_c_q, out_d_q;
   logic [SIDEBAND_WIDTH-1:0] out_sb_q;

   logic                      frag_accept;
   logic                      out_free;
   logic                      out_load;
   logic [PIXEL_WIDTH-1:0]    sel_src, sel_dst;
   logic [SIDEBAND_WIDTH-1:0] sel_sb;

   // A pending config request closes the fragment door in the same cycle, so a
   // fragment arriving together with conf_valid waits for the new factors.
   assign bus.s_ready    = s_ready_q && !bus.conf_valid;
   assign bus.conf_ready = conf_ready_q;
   assign bus.m_valid    = out_valid_q;
   assign bus.m_colorA   = out_a_q;
   assign bus.m_colorB   = out_b_q;
   assign bus.m_colorC   = out_c_q;
   assign bus.m_colorD   = out_d_q;
   assign bus.m_sideband = out_sb_q;

   always_comb begin
      frag_accept = bus.s_valid && s_ready_q && !bus.conf_valid;
      out_free    = !out_valid_q || bus.m_ready;
      out_load    = out_free && (skid_full_q || frag_accept);
      out_valid_d = out_load || (out_valid_q && !bus.m_ready);
      skid_full_d = skid_full_q ? !out_free : (frag_accept && !out_free);
      s_ready_d   = !skid_full_d;
      // The skid is older than anything on the input, so it drains first.
      sel_src     = skid_full_q ? skid_src_q : bus.s_src_color;
      sel_dst     = skid_full_q ? skid_dst_q : bus.s_dst_color;
      sel_sb      = skid_full_q ? skid_sb_q  : bus.s_sideband;
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         skid_full_q <= 1'b0;
         s_ready_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         skid_full_q <= skid_full_d;
         s_ready_q   <= s_ready_d;
      end
   end

   always_ff @(posedge aclk) begin
      if (frag_accept && !out_free) begin
         skid_src_q <= bus.s_src_color;
         skid_dst_q <= bus.s_dst_color;
         skid_sb_q  <= bus.s_sideband;
      end
      if (out_load) begin
         out_a_q  <= sel_src;
         out_b_q  <= factor_f(sfactor_q, sel_src, sel_dst);
         out_c_q  <= sel_dst;
         out_d_q  <= factor_f(dfactor_q, sel_src, sel_dst);
         out_sb_q <= sel_sb;
      end
   end

   // Factors only change with the pipe empty, so every fragment sees one config.
   always_ff @(posedge aclk) begin
      if (reset) begin
         cfg_state_q  <= CFG_RUN;
         conf_ready_q <= 1'b0;
         sfactor_q    <= F_ONE;
         dfactor_q    <= F_ZERO;
      end else begin
         case (cfg_state_q)
            CFG_RUN: begin
               if (bus.conf_valid && !out_valid_q && !skid_full_q) begin
                  cfg_state_q  <= CFG_UPDATE;
                  conf_ready_q <= 1'b1;
               end
            end
            CFG_UPDATE: begin
               if (bus.conf_valid) begin
                  sfactor_q <= bus.conf_sfactor;
                  dfactor_q <= bus.conf_dfactor;
               end
               cfg_state_q  <= CFG_RUN;
               conf_ready_q <= 1'b0;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_blend_factor_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_blend_factor_stage : directed self-checking bench for blend_factor_stage|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_blend_factor_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   blend_factor_stage_if #(.SUB_PIXEL_WIDTH(8), .SIDEBAND_WIDTH(32)) bus_if ();

   blend_factor_stage #(.SUB_PIXEL_WIDTH(8), .SIDEBAND_WIDTH(32)) dut (
      .aclk  (clk),
      .reset (rst),
      .bus   (bus_if.slave)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_config(input logic [3:0] sf, input logic [3:0] df);
      int n;
      n = 0;
      bus_if.conf_valid   = 1'b1;
      bus_if.conf_sfactor = sf;
      bus_if.conf_dfactor = df;
      tick();
      while (!bus_if.conf_ready && n < 50) begin
         tick();
         n++;
      end
      check("conf_ready_seen", 64'(bus_if.conf_ready), 64'd1);
      tick();
      bus_if.conf_valid = 1'b0;
      check("conf_ready_pulse", 64'(bus_if.conf_ready), 64'd0);
   endtask

   task automatic send_and_check(input string tag, input logic [31:0] src, input logic [31:0] dst,
                                 input logic [31:0] exp_b, input logic [31:0] exp_d);
      #1;
      check({tag, "_s_ready"}, 64'(bus_if.s_ready), 64'd1);
      bus_if.m_ready     = 1'b1;
      bus_if.s_valid     = 1'b1;
      bus_if.s_src_color = src;
      bus_if.s_dst_color = dst;
      bus_if.s_sideband  = 32'hA5;
      tick();
      bus_if.s_valid = 1'b0;
      check({tag, "_m_valid"}, 64'(bus_if.m_valid), 64'd1);
      check({tag, "_A"}, 64'(bus_if.m_colorA), 64'(src));
      check({tag, "_B"}, 64'(bus_if.m_colorB), 64'(exp_b));
      check({tag, "_C"}, 64'(bus_if.m_colorC), 64'(dst));
      check({tag, "_D"}, 64'(bus_if.m_colorD), 64'(exp_d));
      tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int sent, rcvd, cyc, viol, any_ready;
      logic s_hs, m_hs;
      logic [31:0] exp_sat;

      bus_if.s_valid = 0; bus_if.s_src_color = '0; bus_if.s_dst_color = '0; bus_if.s_sideband = '0;
      bus_if.conf_valid = 0; bus_if.conf_sfactor = '0; bus_if.conf_dfactor = '0; bus_if.m_ready = 0;

      // Reset state
      tick(); tick(); tick();
      check("rst_m_valid", 64'(bus_if.m_valid), 64'd0);
      check("rst_s_ready", 64'(bus_if.s_ready), 64'd0);
      check("rst_conf_ready", 64'(bus_if.conf_ready), 64'd0);
      rst = 1'b0;
      tick();
      check("post_rst_s_ready", 64'(bus_if.s_ready), 64'd1);

      // Default pass-through config ONE/ZERO
      send_and_check("passthru", 32'h80402010, 32'h11223344, 32'hFFFFFFFF, 32'h00000000);
      check("passthru_drained", 64'(bus_if.m_valid), 64'd0);

      // Factor codes
      do_config(4'd6, 4'd7);
      send_and_check("srca", 32'h11223340, 32'h99887766, 32'h40404040, 32'hBFBFBFBF);
      do_config(4'd2, 4'd5);
      send_and_check("src_invdst", 32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h6543210F);
      do_config(4'd3, 4'd4);
      send_and_check("invsrc_dst", 32'h12345678, 32'h9ABCDEF0, 32'hEDCBA987, 32'h9ABCDEF0);
      do_config(4'd8, 4'd9);
      send_and_check("dsta", 32'h12345678, 32'h9ABCDEF0, 32'hF0F0F0F0, 32'h0F0F0F0F);
      do_config(4'd12, 4'd1);
      send_and_check("code12", 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'hFFFFFFFF);
`ifdef BLEND_SRC_ALPHA_SATURATE_EN
      exp_sat = 32'h7F7F7FFF;
`else
      exp_sat = 32'h00000000;
`endif
      do_config(4'd10, 4'd15);
      send_and_check("saturate", 32'h000000C0, 32'h00000080, exp_sat, 32'h00000000);

      // Config request while two fragments are in flight and the output stalls
      do_config(4'd6, 4'd7);
      bus_if.m_ready = 1'b0;
      bus_if.s_valid = 1'b1; bus_if.s_src_color = 32'h11223344; bus_if.s_dst_color = 32'h0; bus_if.s_sideband = 32'd1;
      tick();
      bus_if.s_src_color = 32'h55667788; bus_if.s_sideband = 32'd2;
      tick();
      bus_if.s_valid = 1'b0;
      bus_if.conf_valid = 1'b1; bus_if.conf_sfactor = 4'd1; bus_if.conf_dfactor = 4'd0;
      #1;
      check("inflight_s_ready", 64'(bus_if.s_ready), 64'd0);
      any_ready = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus_if.conf_ready) any_ready++;
      end
      check("stall_conf_ready", 64'(any_ready), 64'd0);
      check("stall_sb", 64'(bus_if.m_sideband), 64'd1);
      check("stall_B_old", 64'(bus_if.m_colorB), 64'h44444444);
      check("stall_D_old", 64'(bus_if.m_colorD), 64'hBBBBBBBB);
      bus_if.m_ready = 1'b1;
      tick();
      check("drain2_sb", 64'(bus_if.m_sideband), 64'd2);
      check("drain2_B_old", 64'(bus_if.m_colorB), 64'h88888888);
      check("drain2_D_old", 64'(bus_if.m_colorD), 64'h77777777);
      check("drain2_conf_ready", 64'(bus_if.conf_ready), 64'd0);
      tick();
      check("drained_m_valid", 64'(bus_if.m_valid), 64'd0);
      check("drained_conf_ready", 64'(bus_if.conf_ready), 64'd0);
      tick();
      check("update_conf_ready", 64'(bus_if.conf_ready), 64'd1);
      tick();
      check("update_pulse_end", 64'(bus_if.conf_ready), 64'd0);
      bus_if.conf_valid = 1'b0;
      send_and_check("newcfg", 32'h0A0B0C0D, 32'h01020304, 32'hFFFFFFFF, 32'h00000000);

      // Fragment and config arrive together on an empty stage
      bus_if.s_valid = 1'b1; bus_if.s_src_color = 32'h123456AA; bus_if.s_dst_color = 32'h0; bus_if.s_sideband = 32'd9;
      bus_if.conf_valid = 1'b1; bus_if.conf_sfactor = 4'd6; bus_if.conf_dfactor = 4'd0;
      #1;
      check("race_s_ready", 64'(bus_if.s_ready), 64'd0);
      cyc = 0;
      tick();
      while (!bus_if.conf_ready && cyc < 50) begin tick(); cyc++; end
      check("race_conf_ready", 64'(bus_if.conf_ready), 64'd1);
      check("race_no_early_frag", 64'(bus_if.m_valid), 64'd0);
      tick();
      bus_if.conf_valid = 1'b0;
      tick();
      bus_if.s_valid = 1'b0;
      check("race_m_valid", 64'(bus_if.m_valid), 64'd1);
      check("race_B_new", 64'(bus_if.m_colorB), 64'hAAAAAAAA);
      check("race_sb", 64'(bus_if.m_sideband), 64'd9);
      tick();

      // 100-fragment stream with random back-pressure
      sent = 0; rcvd = 0; cyc = 0; viol = 0;
      while (rcvd < 100 && cyc < 3000) begin
         bus_if.m_ready     = 1'($urandom_range(0, 1));
         bus_if.s_valid     = (sent < 100);
         bus_if.s_sideband  = 32'(sent);
         bus_if.s_src_color = 32'(sent * 32'h01010101);
         #1;
         s_hs = bus_if.s_valid && bus_if.s_ready;
         m_hs = bus_if.m_valid && bus_if.m_ready;
         if ((sent - rcvd) >= 2 && bus_if.s_ready) viol++;
         if (m_hs) check("stream_sb", 64'(bus_if.m_sideband), 64'(rcvd));
         tick();
         if (s_hs) sent++;
         if (m_hs) rcvd++;
         cyc++;
      end
      bus_if.s_valid = 1'b0;
      check("stream_count", 64'(rcvd), 64'd100);
      check("stream_ready_skid_full", 64'(viol), 64'd0);

      // Reset in the middle of a stalled transfer
      bus_if.m_ready = 1'b0;
      tick();
      bus_if.s_valid = 1'b1; bus_if.s_src_color = 32'h12345678; bus_if.s_sideband = 32'd7;
      tick();
      bus_if.s_valid = 1'b0;
      check("pre_rst_m_valid", 64'(bus_if.m_valid), 64'd1);
      rst = 1'b1;
      tick();
      check("midrst_m_valid", 64'(bus_if.m_valid), 64'd0);
      check("midrst_s_ready", 64'(bus_if.s_ready), 64'd0);
      rst = 1'b0;
      tick();
      check("midrst_after_s_ready", 64'(bus_if.s_ready), 64'd1);
      check("midrst_after_m_valid", 64'(bus_if.m_valid), 64'd0);
      send_and_check("midrst_cfg", 32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFFF, 32'h00000000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
